// File: rtl/multi_pkg.sv
// multi_pkg: shared widths, FSM state and frame layout for the multiplier-stage frame collector.
package multi_pkg;
   localparam int PROD_W = 11;
   localparam int SUM_W = 13;
   typedef enum logic [1:0] {IDLE, GOT1, GOT3, GOT7} state_t;
   typedef struct packed {
      logic [PROD_W-1:0] p1;
      logic [PROD_W-1:0] p3;
      logic [PROD_W-1:0] p7;
      logic [PROD_W-1:0] p8;
      logic [SUM_W-1:0] sum;
   } frame_t;
endpackage

// File: rtl/frame_fifo2.sv
// frame_fifo2: 2-entry shift-register FIFO of frames; the head is always slot 0 so outputs come straight from a register.
import multi_pkg::*;
module frame_fifo2 #(
   parameter int DEPTH = 2
) (
   input logic clk,
   input logic rst,
   input logic push,
   input logic pop,
   input frame_t din,
   output logic full,
   output logic empty,
   output frame_t head
);
   frame_t r0, r1;
   logic [1:0] count;
   logic push_ok, pop_ok;
   assign full = count == 2'(DEPTH);
   assign empty = count == 2'd0;
   assign pop_ok = pop && !empty;
   assign push_ok = push && (!full || pop_ok);
   assign head = r0;
   always_ff @(posedge clk) begin
      if (rst) begin
         r0 <= '0;
         r1 <= '0;
         count <= 2'd0;
      end else begin
         if (pop_ok && push_ok) begin
            r0 <= (count == 2'd1) ? din : r1;
            if (count == 2'd2) r1 <= din;
         end else if (pop_ok) begin
            r0 <= r1;
         end else if (push_ok) begin
            if (count == 2'd0) r0 <= din;
            else r1 <= din;
         end
         count <= count + {1'b0, push_ok} - {1'b0, pop_ok};
      end
   end
endmodule

// File: rtl/multi_frame_collector.sv
// multi_frame_collector: assembles x1/x3/x7/x8 product sequences into buffered frames with sticky error flags.
// MULTI_CHECK_EN builds the product consistency checker driving chk_err.
import multi_pkg::*;
module multi_frame_collector #(
   parameter int DEPTH = 2
) (
   input logic clk,
   input logic rst,
   input logic input_grant,
   input logic [PROD_W-1:0] out,
   input logic clr,
   output logic m_valid,
   input logic m_ready,
   output logic [PROD_W-1:0] m_p1,
   output logic [PROD_W-1:0] m_p3,
   output logic [PROD_W-1:0] m_p7,
   output logic [PROD_W-1:0] m_p8,
   output logic [SUM_W-1:0] m_sum,
   output logic sync_err,
   output logic overflow,
   output logic chk_err
);
   state_t state, state_n;
   logic [PROD_W-1:0] p1, p3, p7;
   logic push, pop, full, empty;
   frame_t frame, head;
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else state <= state_n;
   end
   always_comb begin
      state_n = input_grant ? GOT1 :
                state == GOT1 ? GOT3 :
                state == GOT3 ? GOT7 : IDLE;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         p1 <= '0;
         p3 <= '0;
         p7 <= '0;
      end else if (input_grant) p1 <= out;
      else if (state == GOT1) p3 <= out;
      else if (state == GOT3) p7 <= out;
   end
   assign push = state == GOT7 && !input_grant;
   assign pop = m_valid && m_ready;
   assign frame = '{p1: p1, p3: p3, p7: p7, p8: out,
                    sum: {2'b0, p1} + {2'b0, p3} + {2'b0, p7} + {2'b0, out}};
   frame_fifo2 #(.DEPTH(DEPTH)) u_fifo (
      .clk(clk),
      .rst(rst),
      .push(push),
      .pop(pop),
      .din(frame),
      .full(full),
      .empty(empty),
      .head(head)
   );
   assign m_valid = !empty;
   assign m_p1 = head.p1;
   assign m_p3 = head.p3;
   assign m_p7 = head.p7;
   assign m_p8 = head.p8;
   assign m_sum = head.sum;
   // set wins over clr
   always_ff @(posedge clk) begin
      if (rst) begin
         sync_err <= 1'b0;
         overflow <= 1'b0;
      end else begin
         sync_err <= (input_grant && state != IDLE) || (sync_err && !clr);
         overflow <= (push && full && !pop) || (overflow && !clr);
      end
   end
`ifdef MULTI_CHECK_EN
   logic bad;
   assign bad = p3 != p1 * 11'd3 || p7 != p1 * 11'd7 || out != p1 << 3;
   always_ff @(posedge clk) begin
      if (rst) chk_err <= 1'b0;
      else chk_err <= (push && bad) || (chk_err && !clr);
   end
`else
   assign chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_multi_frame_collector.sv
// tb_multi_frame_collector: scoreboard bench; expected frames queued at stimulus, compared on each handshake.
import multi_pkg::*;
module tb_multi_frame_collector;
   logic clk = 0, rst = 1, input_grant = 0, clr = 0, m_ready = 1;
   logic [PROD_W-1:0] out = '0;
   logic m_valid, sync_err, overflow, chk_err;
   logic [PROD_W-1:0] m_p1, m_p3, m_p7, m_p8;
   logic [SUM_W-1:0] m_sum;
   int errors = 0, checks = 0;
   frame_t sb[$];
   frame_t got;
   multi_frame_collector #(.DEPTH(2)) dut (
      .clk(clk), .rst(rst), .input_grant(input_grant), .out(out), .clr(clr),
      .m_valid(m_valid), .m_ready(m_ready), .m_p1(m_p1), .m_p3(m_p3), .m_p7(m_p7),
      .m_p8(m_p8), .m_sum(m_sum), .sync_err(sync_err), .overflow(overflow), .chk_err(chk_err)
   );
   always #5 clk = ~clk;
   assign got = {m_p1, m_p3, m_p7, m_p8, m_sum};
   function automatic frame_t mk(input int d);
      frame_t f;
      f.p1 = PROD_W'(d);
      f.p3 = PROD_W'(3 * d);
      f.p7 = PROD_W'(7 * d);
      f.p8 = PROD_W'(8 * d);
      f.sum = SUM_W'(19 * d);
      return f;
   endfunction
   always @(negedge clk) begin
      if (!rst && m_valid && m_ready) begin
         checks++;
         if (sb.size() == 0) begin
            errors++;
            $display("FAIL unexpected_frame: got %h, expected none", got);
         end else begin
            frame_t e;
            e = sb.pop_front();
            if (got !== e) begin
               errors++;
               $display("FAIL frame: got %h, expected %h", got, e);
            end
         end
      end
   end
   task automatic beat(input logic g, input logic [PROD_W-1:0] v);
      input_grant = g;
      out = v;
      @(posedge clk);
      #1;
   endtask
   task automatic send(input int d, input bit keep);
      frame_t f;
      f = mk(d);
      if (keep) sb.push_back(f);
      beat(1, f.p1);
      beat(0, f.p3);
      beat(0, f.p7);
      beat(0, f.p8);
   endtask
   task automatic idle(input int n);
      for (int i = 0; i < n; i++) beat(0, '0);
   endtask
   task automatic pulse_clr;
      clr = 1;
      idle(1);
      clr = 0;
   endtask
   task automatic test_reset;
      rst = 1;
      idle(2);
      checks++;
      if ({m_valid, got, sync_err, overflow, chk_err} !== '0) begin
         errors++;
         $display("FAIL reset_state: got v=%b f=%h flags=%b%b%b, expected all 0", m_valid, got, sync_err, overflow, chk_err);
      end
      rst = 0;
      idle(1);
   endtask
   task automatic test_single;
      m_ready = 1;
      send(5, 1);
      checks++;
      if (m_valid !== 1'b1) begin
         errors++;
         $display("FAIL single_latency: m_valid=%b, expected 1", m_valid);
      end
      idle(1);
      checks++;
      if (m_valid !== 1'b0) begin
         errors++;
         $display("FAIL single_one_cycle: m_valid=%b, expected 0", m_valid);
      end
   endtask
   task automatic test_back_to_back;
      send(255, 1);
      send(1, 1);
      idle(2);
      checks++;
      if ({sync_err, overflow, chk_err} !== 3'b000) begin
         errors++;
         $display("FAIL b2b_flags: got %b%b%b, expected 000", sync_err, overflow, chk_err);
      end
   endtask
   task automatic test_overflow;
      m_ready = 0;
      send(10, 1);
      checks++;
      if (m_valid !== 1'b1 || got !== mk(10)) begin
         errors++;
         $display("FAIL hold_first: v=%b got %h, expected 1 %h", m_valid, got, mk(10));
      end
      send(20, 1);
      send(30, 0);
      checks++;
      if (got !== mk(10)) begin
         errors++;
         $display("FAIL hold_stable: got %h, expected %h", got, mk(10));
      end
      checks++;
      if (overflow !== 1'b1) begin
         errors++;
         $display("FAIL overflow_set: got %b, expected 1", overflow);
      end
      m_ready = 1;
      idle(3);
      checks++;
      if (m_valid !== 1'b0 || sb.size() != 0) begin
         errors++;
         $display("FAIL drain: v=%b pending=%0d, expected 0 0", m_valid, sb.size());
      end
      pulse_clr;
      checks++;
      if (overflow !== 1'b0) begin
         errors++;
         $display("FAIL overflow_clr: got %b, expected 0", overflow);
      end
   endtask
   task automatic test_sync;
      beat(1, 11'd7);
      beat(0, 11'd21);
      send(9, 1);
      idle(1);
      checks++;
      if (sync_err !== 1'b1) begin
         errors++;
         $display("FAIL sync_set: got %b, expected 1", sync_err);
      end
      pulse_clr;
      checks++;
      if (sync_err !== 1'b0) begin
         errors++;
         $display("FAIL sync_clr: got %b, expected 0", sync_err);
      end
   endtask
   task automatic test_check;
      frame_t f;
      logic exp_chk;
      f = mk(5);
      f.p7 = 11'd36;
      f.sum = 13'd96;
      sb.push_back(f);
      beat(1, f.p1);
      beat(0, f.p3);
      beat(0, f.p7);
      beat(0, f.p8);
`ifdef MULTI_CHECK_EN
      exp_chk = 1'b1;
`else
      exp_chk = 1'b0;
`endif
      checks++;
      if (chk_err !== exp_chk) begin
         errors++;
         $display("FAIL chk_err: got %b, expected %b", chk_err, exp_chk);
      end
      idle(1);
   endtask
   task automatic test_mid_reset;
      m_ready = 0;
      send(3, 0);
      beat(1, 11'd4);
      beat(0, 11'd12);
      rst = 1;
      idle(1);
      checks++;
      if ({m_valid, got, sync_err, overflow, chk_err} !== '0) begin
         errors++;
         $display("FAIL mid_reset: got v=%b f=%h flags=%b%b%b, expected all 0", m_valid, got, sync_err, overflow, chk_err);
      end
      rst = 0;
      m_ready = 1;
      send(6, 1);
      checks++;
      if (m_valid !== 1'b1 || got !== mk(6)) begin
         errors++;
         $display("FAIL after_reset: v=%b got %h, expected 1 %h", m_valid, got, mk(6));
      end
      idle(2);
   endtask
   initial begin
      test_reset;
      test_single;
      test_back_to_back;
      test_overflow;
      test_sync;
      test_check;
      test_mid_reset;
      idle(3);
      checks++;
      if (sb.size() != 0) begin
         errors++;
         $display("FAIL missing_frames: pending=%0d, expected 0", sb.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
   initial begin
      #200000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1);
   end
endmodule
